// File: rtl/rws_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rws_arb_pkg
// Description : Shared types and constants for the rws write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rws_arb_pkg;

  typedef enum logic {
    APB_PRIO = 1'b0,
    HW_FORCE = 1'b1
  } arb_state_t;

  localparam int STALL_W = 16;

endpackage
`default_nettype wire

// File: rtl/rws_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rws_rr_pick
// Description : Combinational round-robin select, lowest eligible index at or
//               above the pointer, wrapping to index 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rws_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_elig,
  input  logic [$clog2(NREQ)-1:0] i_rr_ptr,
  output logic [NREQ-1:0]         o_gnt,
  output logic                    o_valid
);

  logic [NREQ-1:0] w_hi;
  logic [NREQ-1:0] w_src;

  always_comb begin
    w_hi = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_hi[i] = i_elig[i] && (i >= int'(i_rr_ptr));
    end
    // Nothing eligible at or above the pointer means the search wraps.
    w_src = (w_hi != '0) ? w_hi : i_elig;
    o_gnt = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_src[i]) begin
        o_gnt    = '0;
        o_gnt[i] = 1'b1;
      end
    end
    o_valid = |i_elig;
  end

endmodule
`default_nettype wire

// File: rtl/rws_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rws_wr_arbiter
// Description : Arbitrates APB (priority) and NREQ hardware writers (round
//               robin) onto the A/B ports of one rws field, with starvation
//               bounding by a single-cycle APB stall.
// Revision    : 1.0 - initial release
// ============================================================================
module rws_wr_arbiter
  import rws_arb_pkg::*;
#(
  parameter int TP         = 1,
  parameter int DWIDTH     = 32,
  parameter int NREQ       = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_apb_wr_en,
  input  logic [DWIDTH-1:0]      i_apb_wr_data,
  output logic                   o_apb_ready,
  input  logic                   i_hw_lock,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ*DWIDTH-1:0] i_req_data,
  output logic [NREQ-1:0]        o_gnt,
  output logic                   o_a_en,
  output logic [DWIDTH-1:0]      o_a_d,
  output logic                   o_b_en,
  output logic [DWIDTH-1:0]      o_b_d,
  output logic [STALL_W-1:0]     o_stall_cnt,
  input  logic                   i_stall_clr
);

  localparam int        PW            = $clog2(NREQ);
  localparam logic [7:0] c_STARVE_LAST = 8'(STARVE_LIM - 1);

  if (NREQ < 2 || NREQ > 8 || STARVE_LIM < 1 || STARVE_LIM > 255 || TP < 0) begin : g_param_chk
    $error("rws_wr_arbiter: parameter out of range");
  end

  arb_state_t         r_state;
  logic               r_a_en;
  logic [DWIDTH-1:0]  r_a_d;
  logic               r_b_en;
  logic [DWIDTH-1:0]  r_b_d;
  logic [NREQ-1:0]    r_gnt;
  logic               r_apb_ready;
  logic [STALL_W-1:0] r_stall_cnt;
  logic [PW-1:0]      r_rr_ptr;
  logic [7:0]         r_starve;

  arb_state_t         w_state_nxt;
  logic [NREQ-1:0]    w_elig;
  logic [NREQ-1:0]    w_pick;
  logic               w_pick_vld;
  logic [PW-1:0]      w_ptr_nxt;
  logic [DWIDTH-1:0]  w_pick_data;
  logic               w_blocked;
  logic               w_starve_hit;
  logic               w_a_en_nxt;
  logic [DWIDTH-1:0]  w_a_d_nxt;
  logic               w_grant;
  logic [7:0]         w_starve_nxt;
  logic               w_ready_nxt;
  logic [STALL_W-1:0] w_stall_nxt;

  // The registered grant masks its requester while the grant is visible.
  assign w_elig = i_hw_lock ? '0 : (i_req & ~r_gnt);

  rws_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .i_elig   (w_elig),
    .i_rr_ptr (r_rr_ptr),
    .o_gnt    (w_pick),
    .o_valid  (w_pick_vld)
  );

  always_comb begin
    w_ptr_nxt   = r_rr_ptr;
    w_pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick[i]) begin
        w_ptr_nxt   = (i == NREQ - 1) ? '0 : PW'(i + 1);
        w_pick_data = i_req_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign w_blocked    = (r_state == APB_PRIO) && i_apb_wr_en && w_pick_vld;
  assign w_starve_hit = w_blocked && (r_starve == c_STARVE_LAST);

  always_comb begin
    w_state_nxt = APB_PRIO;
    case (r_state)
      APB_PRIO: if (w_starve_hit) w_state_nxt = HW_FORCE;
      HW_FORCE: w_state_nxt = APB_PRIO;
      default:  w_state_nxt = APB_PRIO;
    endcase
  end

  always_comb begin
    w_a_en_nxt   = 1'b0;
    w_a_d_nxt    = r_a_d;
    w_grant      = 1'b0;
    w_starve_nxt = '0;
    w_ready_nxt  = 1'b1;
    case (r_state)
      APB_PRIO: begin
        if (i_apb_wr_en) begin
          w_a_en_nxt = 1'b1;
          w_a_d_nxt  = i_apb_wr_data;
        end else begin
          w_grant = w_pick_vld;
        end
        if (w_blocked)    w_starve_nxt = r_starve + 8'd1;
        if (w_starve_hit) w_ready_nxt  = 1'b0;
      end
      HW_FORCE: w_grant = w_pick_vld;
      default:  w_grant = 1'b0;
    endcase
  end

  always_comb begin
    w_stall_nxt = r_stall_cnt;
    if (i_stall_clr)                            w_stall_nxt = '0;
    else if (w_blocked && (r_stall_cnt != '1)) w_stall_nxt = r_stall_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= APB_PRIO;
      r_a_en      <= 1'b0;
      r_a_d       <= '0;
      r_b_en      <= 1'b0;
      r_b_d       <= '0;
      r_gnt       <= '0;
      r_apb_ready <= 1'b1;
      r_stall_cnt <= '0;
      r_rr_ptr    <= '0;
      r_starve    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_a_en      <= w_a_en_nxt;
      r_a_d       <= w_a_d_nxt;
      r_b_en      <= w_grant;
      r_gnt       <= w_grant ? w_pick : '0;
      r_apb_ready <= w_ready_nxt;
      r_stall_cnt <= w_stall_nxt;
      r_starve    <= w_starve_nxt;
      if (w_grant) begin
        r_b_d    <= w_pick_data;
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  assign o_apb_ready = r_apb_ready;
  assign o_gnt       = r_gnt;
  assign o_a_en      = r_a_en;
  assign o_a_d       = r_a_d;
  assign o_b_en      = r_b_en;
  assign o_b_d       = r_b_d;
  assign o_stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rws_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rws_wr_arbiter
// Description : Self-checking bench: directed vector table, corner sequences
//               and randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rws_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int SLIM = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            apb_wr_en;
  logic [DW-1:0]   apb_wr_data;
  logic            apb_ready;
  logic            hw_lock;
  logic [NREQ-1:0] req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0] gnt;
  logic            a_en, b_en;
  logic [DW-1:0]   a_d, b_d;
  logic [15:0]     stall_cnt;
  logic            stall_clr;

  int n_chk  = 0;
  int n_fail = 0;

  // behavioural model state
  bit              m_ready, m_a_en, m_b_en;
  int              m_starve, m_ptr, m_stall;
  logic [NREQ-1:0] m_gnt;
  logic [DW-1:0]   m_a_d, m_b_d;

  rws_wr_arbiter #(.TP(1), .DWIDTH(DW), .NREQ(NREQ), .STARVE_LIM(SLIM)) dut (
    .clk(clk), .rst(rst),
    .i_apb_wr_en(apb_wr_en), .i_apb_wr_data(apb_wr_data), .o_apb_ready(apb_ready),
    .i_hw_lock(hw_lock), .i_req(req), .i_req_data(req_data), .o_gnt(gnt),
    .o_a_en(a_en), .o_a_d(a_d), .o_b_en(b_en), .o_b_d(b_d),
    .o_stall_cnt(stall_cnt), .i_stall_clr(stall_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Spec-level model: APB owns the edge unless stalled; otherwise the first
  // eligible requester in rotating order wins.
  task automatic model_edge();
    logic [NREQ-1:0] elig;
    int  pick;
    bit  apb_take, blocked, grant;
    if (rst) begin
      m_ready = 1; m_starve = 0; m_ptr = 0; m_gnt = '0; m_stall = 0;
      m_a_en = 0; m_a_d = '0; m_b_en = 0; m_b_d = '0;
      return;
    end
    elig = hw_lock ? '0 : (req & ~m_gnt);
    pick = -1;
    for (int k = 0; k < NREQ; k++)
      if (pick < 0 && elig[(m_ptr + k) % NREQ]) pick = (m_ptr + k) % NREQ;
    apb_take = m_ready && apb_wr_en;
    blocked  = apb_take && (pick >= 0);
    grant    = !apb_take && (pick >= 0);
    m_a_en = apb_take;
    if (apb_take) m_a_d = apb_wr_data;
    m_b_en = grant;
    m_gnt  = grant ? NREQ'(1 << pick) : '0;
    if (grant) begin
      m_b_d = req_data[pick*DW +: DW];
      m_ptr = (pick + 1) % NREQ;
    end
    if (stall_clr) m_stall = 0;
    else if (blocked && m_stall < 65535) m_stall++;
    m_ready  = !(blocked && m_starve == SLIM - 1);
    m_starve = (blocked && m_ready) ? m_starve + 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("m_a_en", 64'(a_en), 64'(m_a_en));
    chk("m_a_d", 64'(a_d), 64'(m_a_d));
    chk("m_b_en", 64'(b_en), 64'(m_b_en));
    chk("m_b_d", 64'(b_d), 64'(m_b_d));
    chk("m_gnt", 64'(gnt), 64'(m_gnt));
    chk("m_ready", 64'(apb_ready), 64'(m_ready));
    chk("m_stall", 64'(stall_cnt), 64'(m_stall));
  endtask

  task automatic do_reset();
    rst = 1; apb_wr_en = 0; hw_lock = 0; req = '0; stall_clr = 0;
    tick();
    rst = 0;
  endtask

  typedef struct {
    logic apb; logic [31:0] ad; logic lock; logic [3:0] rq; logic clr;
    logic e_a_en; logic [31:0] e_a_d; logic e_b_en; logic [31:0] e_b_d;
    logic [3:0] e_gnt; logic e_rdy; logic [15:0] e_stall;
  } vec_t;

  vec_t tbl[12];

  localparam logic [31:0] D0 = 32'hD000_0000, D1 = 32'hD000_0011;
  localparam logic [31:0] D2 = 32'hD000_0222, D3 = 32'hD000_3333;
  localparam logic [31:0] A5 = 32'hA5A5_A5A5;

  initial begin
    rst = 1; apb_wr_en = 0; apb_wr_data = '0; hw_lock = 0; req = '0; stall_clr = 0;
    req_data = {D3, D2, D1, D0};

    tbl[0]  = '{0, 0,  0, 4'b0000, 0,  0, 0,  0, 0,  4'b0000, 1, 0};
    tbl[1]  = '{0, 0,  0, 4'b0001, 0,  0, 0,  1, D0, 4'b0001, 1, 0};
    tbl[2]  = '{0, 0,  0, 4'b0000, 0,  0, 0,  0, D0, 4'b0000, 1, 0};
    tbl[3]  = '{0, 0,  0, 4'b1111, 0,  0, 0,  1, D1, 4'b0010, 1, 0};
    tbl[4]  = '{0, 0,  0, 4'b1101, 0,  0, 0,  1, D2, 4'b0100, 1, 0};
    tbl[5]  = '{0, 0,  0, 4'b1001, 0,  0, 0,  1, D3, 4'b1000, 1, 0};
    tbl[6]  = '{0, 0,  0, 4'b0001, 0,  0, 0,  1, D0, 4'b0001, 1, 0};
    tbl[7]  = '{0, 0,  0, 4'b0000, 0,  0, 0,  0, D0, 4'b0000, 1, 0};
    tbl[8]  = '{1, A5, 0, 4'b0100, 0,  1, A5, 0, D0, 4'b0000, 1, 1};
    tbl[9]  = '{0, 0,  0, 4'b0100, 0,  0, A5, 1, D2, 4'b0100, 1, 1};
    tbl[10] = '{0, 0,  0, 4'b0000, 0,  0, A5, 0, D2, 4'b0000, 1, 1};
    tbl[11] = '{0, 0,  0, 4'b0000, 1,  0, A5, 0, D2, 4'b0000, 1, 0};

    // reset state
    do_reset();
    chk("rst_ready", 64'(apb_ready), 64'd1);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_en", 64'({a_en, b_en}), 64'd0);
    chk("rst_data", 64'({a_d, b_d}), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);

    // directed vector table
    for (int r = 0; r < 12; r++) begin
      apb_wr_en = tbl[r].apb; apb_wr_data = tbl[r].ad; hw_lock = tbl[r].lock;
      req = tbl[r].rq; stall_clr = tbl[r].clr;
      tick();
      chk($sformatf("row%0d_a_en", r), 64'(a_en), 64'(tbl[r].e_a_en));
      chk($sformatf("row%0d_a_d", r), 64'(a_d), 64'(tbl[r].e_a_d));
      chk($sformatf("row%0d_b_en", r), 64'(b_en), 64'(tbl[r].e_b_en));
      chk($sformatf("row%0d_b_d", r), 64'(b_d), 64'(tbl[r].e_b_d));
      chk($sformatf("row%0d_gnt", r), 64'(gnt), 64'(tbl[r].e_gnt));
      chk($sformatf("row%0d_ready", r), 64'(apb_ready), 64'(tbl[r].e_rdy));
      chk($sformatf("row%0d_stall", r), 64'(stall_cnt), 64'(tbl[r].e_stall));
    end
    stall_clr = 0;

    // starvation: eight blocked cycles, one stall cycle, then the forced grant
    do_reset();
    apb_wr_en = 1; apb_wr_data = 32'h1234_5678; req = 4'b0010;
    for (int k = 1; k <= SLIM; k++) begin
      tick();
      chk($sformatf("starve%0d_ready", k), 64'(apb_ready), (k < SLIM) ? 64'd1 : 64'd0);
      chk($sformatf("starve%0d_stall", k), 64'(stall_cnt), 64'(k));
      chk($sformatf("starve%0d_gnt", k), 64'(gnt), 64'd0);
    end
    tick();
    chk("force_gnt", 64'(gnt), 64'b0010);
    chk("force_b_en", 64'(b_en), 64'd1);
    chk("force_a_en", 64'(a_en), 64'd0);
    chk("force_ready", 64'(apb_ready), 64'd1);
    req = '0; apb_wr_en = 0;
    tick();

    // lock holds off hardware; stall count must not move
    do_reset();
    apb_wr_en = 1; req = 4'b0001;
    tick();
    apb_wr_en = 0; hw_lock = 1; req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("lock_gnt", 64'(gnt), 64'd0);
      chk("lock_b_en", 64'(b_en), 64'd0);
      chk("lock_stall", 64'(stall_cnt), 64'd1);
    end
    hw_lock = 0;
    tick();
    chk("unlock_gnt", 64'(gnt), 64'b0001);
    req = '0;
    tick();

    // randomized traffic with requesters honouring the handshake
    for (int c = 0; c < 1500; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      apb_wr_en   = ($urandom_range(0, 99) < 60);
      apb_wr_data = $urandom;
      hw_lock     = ($urandom_range(0, 99) < 8);
      stall_clr   = ($urandom_range(0, 99) < 3);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && gnt[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          req_data[i*DW +: DW] = $urandom;
        end else if (!req[i]) begin
          req[i] = ($urandom_range(0, 99) < 30);
          req_data[i*DW +: DW] = $urandom;
        end
      end
      tick();
    end

    // saturate the stall counter under continuous blocking
    do_reset();
    apb_wr_en = 1; req = 4'b0011;
    for (int c = 0; c < 80000 && m_stall < 65535; c++) tick();
    for (int c = 0; c < 20; c++) tick();
    chk("sat_stall", 64'(stall_cnt), 64'hFFFF);
    for (int c = 0; c < 20 && apb_ready !== 1'b1; c++) tick();
    chk("sat_ready_seen", 64'(apb_ready), 64'd1);
    stall_clr = 1;
    tick();
    chk("clr_wins", 64'(stall_cnt), 64'd0);
    stall_clr = 0; apb_wr_en = 0; req = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rws_wr_arbiter.md
# rws_wr_arbiter

Write arbiter that shares one read-write shared register field between the APB register write path and NREQ hardware requesters. Drives the field's port A (APB, priority) and port B (hardware, round-robin) enables and data from registered outputs. Guarantees that a hardware write is never silently overridden by a simultaneous APB write. Bounds hardware starvation by stalling APB via PREADY. Sits between the APB register decoder and one rws_field instance.

## Interface
Parameters:
- TP, 1, time propagation delay on registered assignments
- DWIDTH, 32, field data width
- NREQ, 4, number of hardware requesters (2..8)
- STARVE_LIM, 8, consecutive blocked cycles before APB is stalled (1..255)

Ports:
- clk  input  1  clock; single clock domain, all logic on posedge
- rst  input  1  synchronous reset, active-high
- apb_wr_en  input  1  APB write strobe to this field; held by the master until accepted
- apb_wr_data  input  DWIDTH  APB write data
- apb_ready  output  1  PREADY contribution; write accepted on an edge where apb_wr_en=1 and apb_ready=1
- hw_lock  input  1  software lock; when 1, no hardware grants are issued
- req  input  NREQ  per-requester write request; held with data until granted
- req_data  input  NREQ*DWIDTH  requester i data in bits [i*DWIDTH +: DWIDTH]
- gnt  output  NREQ  one-hot, one-cycle grant pulse
- a_en / a_d  output  1 / DWIDTH  to field port A
- b_en / b_d  output  1 / DWIDTH  to field port B
- stall_cnt  output  16  saturating count of hardware-blocked cycles
- stall_clr  input  1  synchronous clear of stall_cnt

## Operation
- Reset values: a_en=0, a_d=0, b_en=0, b_d=0, gnt=0, apb_ready=1, stall_cnt=0, rr_ptr=0, starve_cnt=0, state=APB_PRIO.
- Eligible set: elig = req & ~gnt (the registered gnt), so a requester is masked on the cycle its grant is visible.
- Round-robin pick: lowest index i ≥ rr_ptr in elig, wrapping modulo NREQ. On grant, rr_ptr <= (i+1) mod NREQ.
- State APB_PRIO:
  - If apb_wr_en=1: a_en<=1 and a_d<=apb_wr_data. No hardware grant this cycle: b_en<=0, gnt<=0.
  - If apb_wr_en=0, elig≠0 and hw_lock=0: grant i, so gnt[i]<=1, b_en<=1, b_d<=req_data[i].
  - A cycle is blocked when elig≠0, hw_lock=0 and apb_wr_en=1. Each blocked cycle increments starve_cnt. Any other cycle clears it.
  - A blocked cycle with starve_cnt=STARVE_LIM-1 sets state<=HW_FORCE and apb_ready<=0.
- State HW_FORCE (exactly one cycle):
  - apb_wr_en is ignored (a_en<=0). Hardware grant issued per pick.
  - Next: state<=APB_PRIO, apb_ready<=1, starve_cnt<=0.
  - If elig became empty or hw_lock rose, no grant is issued, but the state still returns to APB_PRIO.
- hw_lock=1: elig treated as empty; starve_cnt<=0; state forced to APB_PRIO with apb_ready<=1.
- stall_cnt increments on each blocked cycle and saturates at 16'hFFFF. stall_clr=1 sets it to 0 and wins over an increment on the same edge.
- a_en and b_en are never both 1 in the same cycle, so the field's A-over-B priority never drops data.

## Timing
- Latency: sample on edge N; a_en/b_en/gnt are valid during cycle N+1; the field updates on edge N+2.
- Requester handshake: keep req and data stable until gnt[i]=1 is seen. Deassert req or present new data by the following edge.
- Back-to-back grants to different requesters are allowed every cycle. The same requester is granted at most every other cycle.
- APB stall: apb_ready=0 lasts exactly one cycle per starvation event. Worst-case hardware wait is STARVE_LIM+1 cycles under continuous APB traffic with the requester head of rr order; NREQ*(STARVE_LIM+1) worst overall.
- Reset mid-operation: on the reset edge, all pending grants and enables are dropped. Requesters must re-request or keep holding req.

## Structure
- Package rws_arb_pkg: typedef enum logic {APB_PRIO, HW_FORCE} arb_state_t; localparam STALL_W=16.
- Sub-module rws_rr_pick: combinational round-robin select. Inputs are elig and rr_ptr; outputs are a one-hot grant and a valid flag. It is parameterised on NREQ.
- All registers in one always_ff with synchronous rst. Output enables and data are registered; there is no combinational path from req to outputs.

## Test plan
- Reset then idle: after rst, apb_ready=1 and all other outputs are 0. With NREQ=4, req=4'b0001 → gnt=0001, b_en=1 and b_d=req_data[0] one cycle later, then rr_ptr=1.
- Round-robin: hold req=4'b1111 with each requester dropping after its grant → grants in the order 0,1,2,3 on consecutive cycles. No index repeats before wrap.
- Collision: apb_wr_en=1 with data 32'hA5A5_A5A5 while req=4'b0100 → a_en=1, b_en=0, stall_cnt=1. On the next idle APB cycle, gnt=0100.
- Starvation: STARVE_LIM=8, continuous apb_wr_en with req=4'b0010 → after 8 blocked cycles, apb_ready=0 for 1 cycle, gnt=0010 and b_en=1, then apb_ready=1.
- Lock: hw_lock=1 with req=4'b1111 and APB idle for 20 cycles → gnt=0, b_en=0, stall_cnt unchanged. Drop the lock → gnt=0001 next cycle.
- stall_cnt: preload to FFFF via continuous blocking → it stays FFFF. stall_clr coinciding with a blocked cycle → 0.
